// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: round-robin multi-way intersection controller with
// demand-driven way skipping, exact green/yellow/all-red phase durations and
// a night flash mode. All outputs decode from registered state only.
module traffic_light_ctrl #(
    parameter int NUM_WAYS       = 4,
    parameter int GREEN_CYCLES   = 8,
    parameter int YELLOW_CYCLES  = 3,
    parameter int ALL_RED_CYCLES = 2,
    parameter int FLASH_HALF     = 4
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [NUM_WAYS-1:0]                                   demand,
    input  logic                                                  flash,
    output logic [3*NUM_WAYS-1:0]                                 lights,
    output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0]    active_way,
    output logic                                                  green_start
);

    localparam int PW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    // The phase counter must reach the longest phase, and FLASH counts
    // through a whole blink period (two halves).
    localparam int MAX_AB  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    localparam int MAX_CD  = (ALL_RED_CYCLES > 2 * FLASH_HALF) ? ALL_RED_CYCLES : 2 * FLASH_HALF;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] GREEN_LAST   = CW'(GREEN_CYCLES - 1);
    localparam logic [CW-1:0] YELLOW_LAST  = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] ALL_RED_LAST = CW'(ALL_RED_CYCLES - 1);
    localparam logic [CW-1:0] FLASH_ON_END = CW'(FLASH_HALF);
    localparam logic [CW-1:0] FLASH_LAST   = CW'(2 * FLASH_HALF - 1);
    localparam logic [PW-1:0] PTR_RESET    = PW'(NUM_WAYS - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_FLASH   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] next_way;

    // State register: phase, phase counter and served-way pointer.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the same pre-edge values, so no ordering races between flops.
        if (!reset) begin
            state <= S_ALL_RED;
            cnt   <= '0;
            ptr   <= PTR_RESET;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Circular search for the first waiting way after the pointer; falls back
    // to plain rotation when nobody is waiting.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned and no latch is inferred.
        next_way = PW'((int'(ptr) + 1) % NUM_WAYS);
        for (int k = NUM_WAYS; k >= 1; k--) begin
            if (demand[(int'(ptr) + k) % NUM_WAYS]) begin
                next_way = PW'((int'(ptr) + k) % NUM_WAYS);
            end
        end
    end

    // Next-state logic: flash overrides normal sequencing, FLASH exits to ALL_RED.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        ptr_nxt   = ptr;
        if (state == S_FLASH) begin
            if (!flash) begin
                state_nxt = S_ALL_RED;
                cnt_nxt   = '0;
            end else if (cnt == FLASH_LAST) begin
                cnt_nxt = '0;
            end
        end else if (flash) begin
            state_nxt = S_FLASH;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_ALL_RED: begin
                    if (cnt == ALL_RED_LAST) begin
                        state_nxt = S_GREEN;
                        cnt_nxt   = '0;
                        ptr_nxt   = next_way;
                    end
                end
                S_GREEN: begin
                    if (cnt == GREEN_LAST) begin
                        state_nxt = S_YELLOW;
                        cnt_nxt   = '0;
                    end
                end
                S_YELLOW: begin
                    if (cnt == YELLOW_LAST) begin
                        state_nxt = S_ALL_RED;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_ALL_RED;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            lights[3*i +: 3] = LAMP_RED;
        end
        case (state)
            S_GREEN:  lights[3*int'(ptr) +: 3] = LAMP_GREEN;
            S_YELLOW: lights[3*int'(ptr) +: 3] = LAMP_YELLOW;
            S_FLASH: begin
                for (int i = 0; i < NUM_WAYS; i++) begin
                    lights[3*i +: 3] = (cnt < FLASH_ON_END) ? LAMP_YELLOW : LAMP_OFF;
                end
            end
            default: ;
        endcase
        active_way  = ptr;
        green_start = (state == S_GREEN) && (cnt == '0);
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: two instances (default parameters and a
// minimal 2-way configuration). Stimulus pushes the hand-computed expected
// outputs for each cycle into a queue; per-instance monitors pop and compare.
module tb_traffic_light_ctrl;

    typedef struct {
        logic [11:0] lights;
        logic [1:0]  way;
        logic        gs;
    } exp_t;

    logic        clk;
    int          checks = 0;
    int          errors = 0;

    // Instance 1: defaults.
    logic        reset1;
    logic [3:0]  demand1;
    logic        flash1;
    logic [11:0] lights1;
    logic [1:0]  way1;
    logic        gs1;

    // Instance 2: NUM_WAYS=2, all durations 1.
    logic        reset2;
    logic [1:0]  demand2;
    logic        flash2;
    logic [5:0]  lights2;
    logic [0:0]  way2;
    logic        gs2;

    exp_t q1[$];
    exp_t q2[$];

    traffic_light_ctrl u_dut1 (
        .clk        (clk),
        .reset      (reset1),
        .demand     (demand1),
        .flash      (flash1),
        .lights     (lights1),
        .active_way (way1),
        .green_start(gs1)
    );

    traffic_light_ctrl #(
        .NUM_WAYS      (2),
        .GREEN_CYCLES  (1),
        .YELLOW_CYCLES (1),
        .ALL_RED_CYCLES(1),
        .FLASH_HALF    (1)
    ) u_dut2 (
        .clk        (clk),
        .reset      (reset2),
        .demand     (demand2),
        .flash      (flash2),
        .lights     (lights2),
        .active_way (way2),
        .green_start(gs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // All ways red except way w, which shows pat.
    function automatic logic [11:0] one_way(input int n, input int w, input logic [2:0] pat);
        logic [11:0] l;
        l = '0;
        for (int i = 0; i < n; i++) l[3*i +: 3] = (i == w) ? pat : 3'b100;
        return l;
    endfunction

    function automatic logic [11:0] all_ways(input int n, input logic [2:0] pat);
        logic [11:0] l;
        l = '0;
        for (int i = 0; i < n; i++) l[3*i +: 3] = pat;
        return l;
    endfunction

    // Advance one edge, then record what the DUT must show for that cycle.
    task automatic t1(input logic [11:0] l, input logic [1:0] w, input logic g);
        exp_t e;
        @(posedge clk);
        #1;
        e.lights = l; e.way = w; e.gs = g;
        q1.push_back(e);
    endtask

    task automatic t2(input logic [11:0] l, input logic [1:0] w, input logic g);
        exp_t e;
        @(posedge clk);
        #1;
        e.lights = l; e.way = w; e.gs = g;
        q2.push_back(e);
    endtask

    task automatic green1(input int w, input int n);
        for (int i = 0; i < n; i++) t1(one_way(4, w, 3'b001), 2'(w), i == 0);
    endtask

    task automatic serve1(input int w);
        green1(w, 8);
        for (int i = 0; i < 3; i++) t1(one_way(4, w, 3'b010), 2'(w), 1'b0);
        for (int i = 0; i < 2; i++) t1(all_ways(4, 3'b100), 2'(w), 1'b0);
    endtask

    task automatic stim1();
        reset1 = 1'b0; demand1 = 4'b1111; flash1 = 1'b0;
        t1(all_ways(4, 3'b100), 2'd3, 1'b0);
        t1(all_ways(4, 3'b100), 2'd3, 1'b0);
        reset1 = 1'b1;
        t1(all_ways(4, 3'b100), 2'd3, 1'b0);
        // Full demand: plain rotation 0,1,2,3,0.
        serve1(0); serve1(1); serve1(2); serve1(3); serve1(0);
        // Single waiting way is re-served every 13 cycles.
        demand1 = 4'b0100;
        serve1(2); serve1(2);
        demand1 = 4'b0001;
        serve1(0);
        // From way0, ways 1 and 2 are skipped.
        demand1 = 4'b1001;
        serve1(3); serve1(0);
        // No demand: fixed-time fallback rotation.
        demand1 = 4'b0000;
        green1(1, 4);
        // Flash entry at way1 green cnt=3, immediate, pointer held.
        flash1 = 1'b1;
        for (int i = 0; i < 10; i++)
            t1(all_ways(4, ((i % 8) < 4) ? 3'b010 : 3'b000), 2'd1, 1'b0);
        flash1 = 1'b0;
        t1(all_ways(4, 3'b100), 2'd1, 1'b0);
        t1(all_ways(4, 3'b100), 2'd1, 1'b0);
        serve1(2);
        // Reset during way3 yellow wins over a simultaneous flash request.
        green1(3, 8);
        t1(one_way(4, 3, 3'b010), 2'd3, 1'b0);
        reset1 = 1'b0; flash1 = 1'b1;
        t1(all_ways(4, 3'b100), 2'd3, 1'b0);
        reset1 = 1'b1; flash1 = 1'b0;
        t1(all_ways(4, 3'b100), 2'd3, 1'b0);
        serve1(0);
    endtask

    task automatic stim2();
        reset2 = 1'b0; demand2 = 2'b11; flash2 = 1'b0;
        t2(all_ways(2, 3'b100), 2'd1, 1'b0);
        reset2 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 2; w++) begin
                t2(one_way(2, w, 3'b001), 2'(w), 1'b1);
                t2(one_way(2, w, 3'b010), 2'(w), 1'b0);
                t2(all_ways(2, 3'b100), 2'(w), 1'b0);
            end
        end
        t2(one_way(2, 0, 3'b001), 2'd0, 1'b1);
        flash2 = 1'b1;
        t2(all_ways(2, 3'b010), 2'd0, 1'b0);
        t2(all_ways(2, 3'b000), 2'd0, 1'b0);
        t2(all_ways(2, 3'b010), 2'd0, 1'b0);
        flash2 = 1'b0;
        t2(all_ways(2, 3'b100), 2'd0, 1'b0);
        demand2 = 2'b00;
        t2(one_way(2, 1, 3'b001), 2'd1, 1'b1);
        t2(one_way(2, 1, 3'b010), 2'd1, 1'b0);
        t2(all_ways(2, 3'b100), 2'd1, 1'b0);
        t2(one_way(2, 0, 3'b001), 2'd0, 1'b1);
    endtask

    // Monitor for instance 1: compare the presented outputs to the scoreboard.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1.lights", 32'(lights1), 32'(e.lights));
            check("dut1.active_way", 32'(way1), 32'(e.way));
            check("dut1.green_start", 32'(gs1), 32'(e.gs));
        end
    end

    // Monitor for instance 2.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("dut2.lights", 32'(lights2), 32'(e.lights[5:0]));
            check("dut2.active_way", 32'(way2), 32'(e.way[0]));
            check("dut2.green_start", 32'(gs2), 32'(e.gs));
        end
    end

    initial begin
        reset1 = 1'b0; demand1 = '0; flash1 = 1'b0;
        reset2 = 1'b0; demand2 = '0; flash2 = 1'b0;
        fork
            stim1();
            stim2();
        join
        @(negedge clk);
        #1;
        check("q1.drained", 32'(q1.size()), 32'd0);
        check("q2.drained", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
